ex_mem_stage: RTL and testbench

- EX/MEM pipeline register of the LEGv8 datapath, directly downstream of the execute-stage ALU.
- Captures the ALU result, zero flag, store data, destination register, branch target and MEM/WB control bits each cycle.
- Resolves conditional and unconditional branches (pcsrc) from the registered zero flag.
- Holds the pipeline while a multi-cycle data-memory access is outstanding, and counts stall cycles.

---
 rtl/ex_mem_stage_if.sv | 56 +++++
 rtl/ex_mem_stage.sv | 115 +++++++++++
 tb/tb_ex_mem_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: bundle of the signals between the execute stage, the
// EX/MEM pipeline register and the data-memory handshake.
//   master : EX side; drives ex_* fields, flush and mem_ready, observes mem_* outputs
//   slave  : the EX/MEM register (ex_mem_stage)
// Parameters: N = datapath width, CW = stall-cycle counter width.
interface ex_mem_stage_if #(
    parameter int unsigned N  = 64,
    parameter int unsigned CW = 32
);
    logic          ex_valid;
    logic [N-1:0]  ex_result;
    logic          ex_zero;
    logic [N-1:0]  ex_wdata;
    logic [4:0]    ex_rd;
    logic [N-1:0]  ex_target;
    logic          ex_branch;
    logic          ex_uncond;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_regwrite;
    logic          ex_memtoreg;
    logic          flush;
    logic          mem_ready;

    logic          mem_valid;
    logic [N-1:0]  mem_result;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_target;
    logic          mem_zero;
    logic [4:0]    mem_rd;
    logic          mem_memread;
    logic          mem_memwrite;
    logic          mem_regwrite;
    logic          mem_memtoreg;
    logic          pcsrc;
    logic          stall;
    logic [CW-1:0] stall_cycles;

    modport master (
        output ex_valid, ex_result, ex_zero, ex_wdata, ex_rd, ex_target, ex_branch,
               ex_uncond, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, flush,
               mem_ready,
        input  mem_valid, mem_result, mem_wdata, mem_target, mem_zero, mem_rd,
               mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, pcsrc, stall,
               stall_cycles
    );

    modport slave (
        input  ex_valid, ex_result, ex_zero, ex_wdata, ex_rd, ex_target, ex_branch,
               ex_uncond, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, flush,
               mem_ready,
        output mem_valid, mem_result, mem_wdata, mem_target, mem_zero, mem_rd,
               mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, pcsrc, stall,
               stall_cycles
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: LEGv8 EX/MEM pipeline register.
// Captures the execute-stage results and MEM/WB control each cycle, resolves
// branches from the registered zero flag and holds while a data-memory access
// is outstanding, counting stalled cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : ex_mem_stage_if.slave (EX inputs, flush, mem_ready, mem_* outputs,
//           pcsrc, stall, stall_cycles)
module ex_mem_stage #(
    parameter int unsigned N  = 64,
    parameter int unsigned CW = 32
) (
    input  logic           clk,
    input  logic           reset,
    ex_mem_stage_if.slave  bus
);

    // StWait: valid instruction with a memory op; it is busy until mem_ready.
    typedef enum logic [1:0] {StEmpty, StFull, StWait} state_e;

    state_e        state_q;
    logic          flush_pend_q;
    logic [N-1:0]  result_q;
    logic [N-1:0]  wdata_q;
    logic [N-1:0]  target_q;
    logic          zero_q;
    logic [4:0]    rd_q;
    logic          branch_q;
    logic          uncond_q;
    logic          memread_q;
    logic          memwrite_q;
    logic          regwrite_q;
    logic          memtoreg_q;
    logic [CW-1:0] stall_cnt_q;

    logic valid;
    logic busy;

    assign valid = (state_q != StEmpty);
    assign busy  = (state_q == StWait) & ~bus.mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StEmpty;
            flush_pend_q <= 1'b0;
            result_q     <= '0;
            wdata_q      <= '0;
            target_q     <= '0;
            zero_q       <= 1'b0;
            rd_q         <= '0;
            branch_q     <= 1'b0;
            uncond_q     <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            if (busy && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CW'(1);
            end

            if (busy) begin
                // Hold the in-flight access; remember a flush for the next capture.
                if (bus.flush) begin
                    flush_pend_q <= 1'b1;
                end
            end else if (bus.flush || flush_pend_q || !bus.ex_valid) begin
                state_q      <= StEmpty;
                flush_pend_q <= 1'b0;
                result_q     <= '0;
                wdata_q      <= '0;
                target_q     <= '0;
                zero_q       <= 1'b0;
                rd_q         <= '0;
                branch_q     <= 1'b0;
                uncond_q     <= 1'b0;
                memread_q    <= 1'b0;
                memwrite_q   <= 1'b0;
                regwrite_q   <= 1'b0;
                memtoreg_q   <= 1'b0;
            end else begin
                state_q    <= (bus.ex_memread || bus.ex_memwrite) ? StWait : StFull;
                result_q   <= bus.ex_result;
                wdata_q    <= bus.ex_wdata;
                target_q   <= bus.ex_target;
                zero_q     <= bus.ex_zero;
                rd_q       <= bus.ex_rd;
                branch_q   <= bus.ex_branch;
                uncond_q   <= bus.ex_uncond;
                memread_q  <= bus.ex_memread;
                memwrite_q <= bus.ex_memwrite;
                regwrite_q <= bus.ex_regwrite;
                memtoreg_q <= bus.ex_memtoreg;
            end
        end
    end

    assign bus.mem_valid    = valid;
    assign bus.mem_result   = result_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_target   = target_q;
    assign bus.mem_zero     = zero_q;
    assign bus.mem_rd       = rd_q;
    // Control is gated by valid so a bubble can never issue a side effect.
    assign bus.mem_memread  = valid & memread_q;
    assign bus.mem_memwrite = valid & memwrite_q;
    assign bus.mem_regwrite = valid & regwrite_q;
    assign bus.mem_memtoreg = valid & memtoreg_q;
    assign bus.pcsrc        = valid & ((branch_q & zero_q) | uncond_q);
    assign bus.stall        = busy;
    assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage (built with CW=4 so saturation is reachable).
module tb_ex_mem_stage;

    localparam int unsigned N  = 64;
    localparam int unsigned CW = 4;

    logic clk;
    logic reset;

    ex_mem_stage_if #(.N(N), .CW(CW)) bus ();

    ex_mem_stage #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [63:0] result;
        logic        zero;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] target;
        logic        branch;
        logic        uncond;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic        memtoreg;
        logic        flush;
        logic        ready;
    } ex_in_t;

    // ctrl = {memread, memwrite, regwrite, memtoreg}
    typedef struct {
        logic        valid;
        logic        pcsrc;
        logic [3:0]  ctrl;
        logic [63:0] result;
        logic [63:0] wdata;
        logic [63:0] target;
        logic [4:0]  rd;
        logic        zero;
        logic        stall;
    } exp_t;

    typedef struct {
        ex_in_t in;
        exp_t   exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input ex_in_t v);
        bus.ex_valid    = v.valid;
        bus.ex_result   = v.result;
        bus.ex_zero     = v.zero;
        bus.ex_wdata    = v.wdata;
        bus.ex_rd       = v.rd;
        bus.ex_target   = v.target;
        bus.ex_branch   = v.branch;
        bus.ex_uncond   = v.uncond;
        bus.ex_memread  = v.memread;
        bus.ex_memwrite = v.memwrite;
        bus.ex_regwrite = v.regwrite;
        bus.ex_memtoreg = v.memtoreg;
        bus.flush       = v.flush;
        bus.mem_ready   = v.ready;
    endtask

    task automatic check_exp(input string tag, input exp_t e);
        chk({tag, " valid"},  64'(bus.mem_valid), 64'(e.valid));
        chk({tag, " pcsrc"},  64'(bus.pcsrc), 64'(e.pcsrc));
        chk({tag, " ctrl"},   64'({bus.mem_memread, bus.mem_memwrite,
                                   bus.mem_regwrite, bus.mem_memtoreg}), 64'(e.ctrl));
        chk({tag, " result"}, bus.mem_result, e.result);
        chk({tag, " wdata"},  bus.mem_wdata, e.wdata);
        chk({tag, " target"}, bus.mem_target, e.target);
        chk({tag, " rd"},     64'(bus.mem_rd), 64'(e.rd));
        chk({tag, " zero"},   64'(bus.mem_zero), 64'(e.zero));
        chk({tag, " stall"},  64'(bus.stall), 64'(e.stall));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t   tbl[11];
    ex_in_t in;

    initial begin
        //            valid result       z  wdata        rd    target       br un rd wr rw mr fl rdy
        tbl[0]  = '{'{1, 64'h0,       1, 64'h0,      5'd0, 64'h400, 1, 0, 0, 0, 0, 0, 0, 1},
                    '{1, 1, 4'b0000, 64'h0, 64'h0, 64'h400, 5'd0, 1, 0}};
        tbl[1]  = '{'{0, 64'h77,      0, 64'h0,      5'd4, 64'h0,   0, 0, 0, 0, 1, 0, 0, 1},
                    '{0, 0, 4'b0000, 64'h0, 64'h0, 64'h0, 5'd0, 0, 0}};
        tbl[2]  = '{'{1, 64'h0,       0, 64'h0,      5'd0, 64'h404, 1, 0, 0, 0, 0, 0, 0, 1},
                    '{1, 0, 4'b0000, 64'h0, 64'h0, 64'h404, 5'd0, 0, 0}};
        tbl[3]  = '{'{1, 64'h0,       0, 64'h0,      5'd0, 64'h800, 0, 1, 0, 0, 0, 0, 0, 1},
                    '{1, 1, 4'b0000, 64'h0, 64'h0, 64'h800, 5'd0, 0, 0}};
        tbl[4]  = '{'{1, 64'h10,      0, 64'h99,     5'd2, 64'h0,   0, 0, 0, 1, 0, 0, 1, 1},
                    '{0, 0, 4'b0000, 64'h0, 64'h0, 64'h0, 5'd0, 0, 0}};
        tbl[5]  = '{'{1, 64'hdead,    0, 64'h0,      5'd7, 64'h0,   0, 0, 0, 0, 1, 0, 0, 0},
                    '{1, 0, 4'b0010, 64'hdead, 64'h0, 64'h0, 5'd7, 0, 0}};
        tbl[6]  = '{'{1, 64'h1234,    1, 64'h0,      5'd8, 64'h0,   0, 0, 0, 0, 1, 0, 0, 0},
                    '{1, 0, 4'b0010, 64'h1234, 64'h0, 64'h0, 5'd8, 1, 0}};
        tbl[7]  = '{'{1, 64'h40,      0, 64'hcafe,   5'd0, 64'h0,   0, 0, 0, 1, 0, 0, 0, 1},
                    '{1, 0, 4'b0100, 64'h40, 64'hcafe, 64'h0, 5'd0, 0, 0}};
        tbl[8]  = '{'{1, 64'h48,      0, 64'h0,      5'd6, 64'h0,   0, 0, 1, 0, 1, 1, 0, 1},
                    '{1, 0, 4'b1011, 64'h48, 64'h0, 64'h0, 5'd6, 0, 0}};
        tbl[9]  = '{'{1, 64'h0,       0, 64'h0,      5'd0, 64'hc00, 0, 1, 0, 0, 0, 0, 1, 1},
                    '{0, 0, 4'b0000, 64'h0, 64'h0, 64'h0, 5'd0, 0, 0}};
        tbl[10] = '{'{1, 64'h5,       0, 64'h0,      5'd1, 64'h0,   0, 0, 0, 0, 1, 0, 0, 1},
                    '{1, 0, 4'b0010, 64'h5, 64'h0, 64'h0, 5'd1, 0, 0}};

        // Reset held with a live instruction presented.
        reset = 1'b1;
        in = '{1, 64'h10, 0, 64'h0, 5'd0, 64'h0, 0, 0, 0, 0, 1, 0, 0, 1};
        drive(in);
        #2 reset = 1'b0;
        tick();
        tick();
        check_exp("reset", '{0, 0, 4'b0000, 64'h0, 64'h0, 64'h0, 5'd0, 0, 0});
        chk("reset stall_cycles", 64'(bus.stall_cycles), 64'd0);
        #2 reset = 1'b1;
        tick();
        check_exp("first capture", '{1, 0, 4'b0010, 64'h10, 64'h0, 64'h0, 5'd0, 0, 0});

        // Table vectors through the scoreboard.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].in);
            sb.push_back(tbl[i].exp);
            tick();
            check_exp($sformatf("vec%0d", i), sb.pop_front());
        end
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        // Load stalled three cycles while EX presents a new instruction.
        in = '{1, 64'h100, 0, 64'h0, 5'd5, 64'h0, 0, 0, 1, 0, 1, 1, 0, 1};
        drive(in);
        tick();
        bus.mem_ready = 1'b0;
        in = '{1, 64'h55, 0, 64'h0, 5'd9, 64'h0, 0, 0, 0, 0, 1, 0, 0, 0};
        drive(in);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("load wait%0d stall", c), 64'(bus.stall), 64'd1);
            chk($sformatf("load wait%0d rd", c), 64'(bus.mem_rd), 64'd5);
            tick();
        end
        chk("load held result", bus.mem_result, 64'h100);
        chk("load stall_cycles", 64'(bus.stall_cycles), 64'd3);
        bus.mem_ready = 1'b1;
        #1;
        chk("load ready stall", 64'(bus.stall), 64'd0);
        tick();
        check_exp("after load", '{1, 0, 4'b0010, 64'h55, 64'h0, 64'h0, 5'd9, 0, 0});

        // Store stalled; flush on the second wait cycle.
        in = '{1, 64'h60, 0, 64'habc, 5'd3, 64'h0, 0, 0, 0, 1, 0, 0, 0, 1};
        drive(in);
        tick();
        in = '{1, 64'h77, 0, 64'h0, 5'd11, 64'h0, 0, 0, 0, 0, 1, 0, 0, 0};
        drive(in);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        check_exp("flush wait held", '{1, 0, 4'b0100, 64'h60, 64'habc, 64'h0, 5'd3, 0, 1});
        chk("flush stall_cycles", 64'(bus.stall_cycles), 64'd6);
        bus.mem_ready = 1'b1;
        tick();
        check_exp("flush bubble", '{0, 0, 4'b0000, 64'h0, 64'h0, 64'h0, 5'd0, 0, 0});
        tick();
        check_exp("flush reload", '{1, 0, 4'b0010, 64'h77, 64'h0, 64'h0, 5'd11, 0, 0});

        // Long load stall saturates the 4-bit counter, then async reset mid-wait.
        in = '{1, 64'h200, 0, 64'h0, 5'd12, 64'h0, 0, 0, 1, 0, 1, 1, 0, 1};
        drive(in);
        tick();
        bus.mem_ready = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        chk("sat stall_cycles", 64'(bus.stall_cycles), 64'd15);
        chk("sat stall", 64'(bus.stall), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_exp("async reset", '{0, 0, 4'b0000, 64'h0, 64'h0, 64'h0, 5'd0, 0, 0});
        chk("async reset stall_cycles", 64'(bus.stall_cycles), 64'd0);
        #2 reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
